// File: rtl/histogram_top.sv
// 3x3 majority filter for a binary image with saturating
// column/row projection histograms streamed out on request.
module histogram_top #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 180,
  parameter int AW     = 8,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          filterDone,
  output logic          filterReady,
  input  logic          dataIn,
  output logic [AW-1:0] xAddressOut,
  output logic [AW-1:0] yAddressOut,
  output logic [AW-1:0] xMedianAddress,
  output logic [AW-1:0] yMedianAddress,
  output logic          writeEnable,
  output logic          dataOut,
  input  logic          readHistogram,
  input  logic          clearHistogram,
  output logic [CW-1:0] xHistogramOut,
  output logic [CW-1:0] yHistogramOut,
  output logic          xValid,
  output logic          yValid,
  output logic          histogramClear,
  output logic          ready
);

  localparam int N = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;

  typedef enum logic [2:0] {
    F_IDLE, F_A0, F_A1, F_A2, F_CAP, F_WR
  } fstate_t;

  typedef enum logic [1:0] {
    H_IDLE, H_ACCUM, H_READ, H_CLEAR
  } hstate_t;

  fstate_t fs, fs_nx;
  hstate_t hs, hs_nx;

  logic [AW-1:0] x, y, k;
  logic          prime;
  logic [2:0]    r0, r1, r2;
  logic [1:0]    nr;
  logic          oob_q;
  logic          done_q;
  logic          clr_q;
  logic [CW-1:0] xbin [WIDTH];
  logic [CW-1:0] ybin [HEIGHT];

  logic          go, clr_go, rd_go;
  logic          last_px, fetch, inb, pix, med, col_end;
  logic [AW:0]   col, row;
  logic [8:0]    w9;
  logic [3:0]    ones;

  assign go     = start && ready;
  assign clr_go = clearHistogram && ready && !start;
  assign rd_go  = readHistogram && ready && !start
                  && !clearHistogram;

  assign col_end = (y == AW'(HEIGHT - 1));
  assign last_px = (fs == F_WR) && col_end
                   && (x == AW'(WIDTH - 1));

  // Priming fetches row y itself; normal fetches row y+1.
  always_comb begin
    col = {1'b0, x};
    if (fs == F_A0) col = {1'b0, x} - (AW+1)'(1);
    if (fs == F_A2) col = {1'b0, x} + (AW+1)'(1);
    row = prime ? {1'b0, y} : {1'b0, y} + (AW+1)'(1);
  end

  assign fetch = (fs == F_A0) || (fs == F_A1) || (fs == F_A2);
  assign inb   = fetch && (col < (AW+1)'(WIDTH))
                 && (row < (AW+1)'(HEIGHT));
  assign pix   = dataIn && !oob_q;

  assign xAddressOut = inb ? col[AW-1:0] : '0;
  assign yAddressOut = inb ? row[AW-1:0] : '0;

  assign w9 = {r2, r1, r0};
  always_comb begin
    ones = '0;
    for (int i = 0; i < 9; i++) ones = ones + {3'b0, w9[i]};
  end
  assign med = (ones >= 4'd5);

  assign writeEnable    = (fs == F_WR);
  assign dataOut        = writeEnable && med;
  assign xMedianAddress = writeEnable ? x : '0;
  assign yMedianAddress = writeEnable ? y : '0;
  assign filterReady    = (fs == F_IDLE);
  assign filterDone     = done_q;

  always_ff @(posedge clk) begin
    if (reset) fs <= F_IDLE;
    else       fs <= fs_nx;
  end

  always_comb begin
    fs_nx = fs;
    unique case (fs)
      F_IDLE: if (go) fs_nx = F_A0;
      F_A0:   fs_nx = F_A1;
      F_A1:   fs_nx = F_A2;
      F_A2:   fs_nx = F_CAP;
      F_CAP:  fs_nx = prime ? F_A0 : F_WR;
      F_WR:   fs_nx = last_px ? F_IDLE : F_A0;
      default: fs_nx = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      prime  <= 1'b0;
      r0     <= '0;
      r1     <= '0;
      r2     <= '0;
      nr     <= '0;
      oob_q  <= 1'b1;
      done_q <= 1'b0;
    end else begin
      oob_q  <= !inb;
      done_q <= last_px;
      if (fs == F_IDLE && go) begin
        x     <= '0;
        y     <= '0;
        prime <= 1'b1;
        r0    <= '0;
        r1    <= '0;
        r2    <= '0;
      end
      if (fs == F_A1) nr[0] <= pix;
      if (fs == F_A2) nr[1] <= pix;
      if (fs == F_CAP) begin
        r0    <= r1;
        r1    <= r2;
        r2    <= {pix, nr[1], nr[0]};
        prime <= 1'b0;
      end
      if (fs == F_WR && !last_px) begin
        if (col_end) begin
          x     <= x + AW'(1);
          y     <= '0;
          prime <= 1'b1;
          r0    <= '0;
          r1    <= '0;
          r2    <= '0;
        end else begin
          y <= y + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) hs <= H_IDLE;
    else       hs <= hs_nx;
  end

  always_comb begin
    hs_nx = hs;
    unique case (hs)
      H_IDLE: begin
        if (go)          hs_nx = H_ACCUM;
        else if (clr_go) hs_nx = H_CLEAR;
        else if (rd_go)  hs_nx = H_READ;
      end
      H_ACCUM: if (last_px) hs_nx = H_IDLE;
      H_READ:  if (k == AW'(N - 1)) hs_nx = H_IDLE;
      H_CLEAR: if (k == AW'(N - 1)) hs_nx = H_IDLE;
      default: hs_nx = H_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k     <= '0;
      clr_q <= 1'b0;
    end else begin
      clr_q <= (hs == H_CLEAR) && (k == AW'(N - 1));
      if ((hs == H_READ || hs == H_CLEAR) && k != AW'(N - 1))
        k <= k + AW'(1);
      else
        k <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++)  xbin[i] <= '0;
      for (int i = 0; i < HEIGHT; i++) ybin[i] <= '0;
    end else if (hs == H_CLEAR) begin
      if (k < AW'(WIDTH))  xbin[k] <= '0;
      if (k < AW'(HEIGHT)) ybin[k] <= '0;
    end else if (hs == H_ACCUM && dataOut) begin
      if (xbin[x] != '1) xbin[x] <= xbin[x] + CW'(1);
      if (ybin[y] != '1) ybin[y] <= ybin[y] + CW'(1);
    end
  end

  assign xValid         = (hs == H_READ) && (k < AW'(WIDTH));
  assign yValid         = (hs == H_READ) && (k < AW'(HEIGHT));
  assign xHistogramOut  = xValid ? xbin[k] : '0;
  assign yHistogramOut  = yValid ? ybin[k] : '0;
  assign histogramClear = clr_q;
  assign ready          = (hs == H_IDLE) && filterReady;

endmodule

// File: tb/tb_histogram_top.sv
// Scoreboard bench for histogram_top on a reduced 24x18 image
// with 5-bit bins so that saturation is reachable.
module tb_histogram_top;

  localparam int W    = 24;
  localparam int H    = 18;
  localparam int AW   = 8;
  localparam int CW   = 5;
  localparam int N    = (W > H) ? W : H;
  localparam int BMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          readHistogram = 1'b0;
  logic          clearHistogram = 1'b0;
  logic          dataIn;
  logic          filterDone, filterReady;
  logic [AW-1:0] xAddressOut, yAddressOut;
  logic [AW-1:0] xMedianAddress, yMedianAddress;
  logic          writeEnable, dataOut;
  logic [CW-1:0] xHistogramOut, yHistogramOut;
  logic          xValid, yValid, histogramClear, ready;

  histogram_top #(
    .WIDTH(W), .HEIGHT(H), .AW(AW), .CW(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .filterDone(filterDone),
    .filterReady(filterReady),
    .dataIn(dataIn),
    .xAddressOut(xAddressOut),
    .yAddressOut(yAddressOut),
    .xMedianAddress(xMedianAddress),
    .yMedianAddress(yMedianAddress),
    .writeEnable(writeEnable),
    .dataOut(dataOut),
    .readHistogram(readHistogram),
    .clearHistogram(clearHistogram),
    .xHistogramOut(xHistogramOut),
    .yHistogramOut(yHistogramOut),
    .xValid(xValid),
    .yValid(yValid),
    .histogramClear(histogramClear),
    .ready(ready)
  );

  always #5 clk = ~clk;

  bit src [W][H];
  bit fm  [W][H];
  int mx [W];
  int my [H];
  int gx [W];
  int gy [H];
  int wq [$];
  int xq [$];
  int yq [$];
  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int xv_cnt = 0;
  int yv_cnt = 0;

  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pk(int px, int py, int d);
    return (px << 16) | (py << 8) | d;
  endfunction

  function automatic int maj(int px, int py);
    int c = 0;
    for (int dx = -1; dx <= 1; dx++)
      for (int dy = -1; dy <= 1; dy++)
        if (px+dx >= 0 && px+dx < W && py+dy >= 0 && py+dy < H)
          c += src[px+dx][py+dy];
    return (c >= 5) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    if (int'(xAddressOut) < W && int'(yAddressOut) < H)
      dataIn <= src[int'(xAddressOut)][int'(yAddressOut)];
    else
      dataIn <= 1'b0;
  end

  always @(negedge clk) begin
    if (writeEnable) begin
      wr_cnt++;
      if (int'(xMedianAddress) < W && int'(yMedianAddress) < H)
        fm[int'(xMedianAddress)][int'(yMedianAddress)] = dataOut;
      if (wq.size() == 0) check("wr_extra", 1, 0);
      else check("wr", pk(int'(xMedianAddress),
                 int'(yMedianAddress), int'(dataOut)), wq.pop_front());
    end
    if (xValid) begin
      if (xv_cnt < W) gx[xv_cnt] = int'(xHistogramOut);
      xv_cnt++;
      if (xq.size() == 0) check("xbin_extra", 1, 0);
      else check("xbin", int'(xHistogramOut), xq.pop_front());
    end
    if (yValid) begin
      if (yv_cnt < H) gy[yv_cnt] = int'(yHistogramOut);
      yv_cnt++;
      if (yq.size() == 0) check("ybin_extra", 1, 0);
      else check("ybin", int'(yHistogramOut), yq.pop_front());
    end
    if (filterDone) begin
      done_cnt++;
      check("done_rdy", int'(filterReady), 1);
    end
  end

  task automatic zero_model();
    for (int i = 0; i < W; i++) mx[i] = 0;
    for (int i = 0; i < H; i++) my[i] = 0;
  endtask

  task automatic run_frame();
    int d0, e;
    bit seen;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < H; j++) begin
        e = maj(i, j);
        wq.push_back(pk(i, j, e));
        if (e == 1) begin
          if (mx[i] < BMAX) mx[i]++;
          if (my[j] < BMAX) my[j]++;
        end
      end
    d0 = done_cnt;
    seen = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("busy", int'(filterReady), 0);
    for (int c = 0; c < W*H*6 + 200; c++) begin
      @(negedge clk);
      if (done_cnt != d0) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("frame_timeout", 0, 1);
    repeat (3) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("wq_left", wq.size(), 0);
    check("rdy_after", int'(ready), 1);
  endtask

  task automatic read_hist();
    bit seen;
    for (int i = 0; i < W; i++) xq.push_back(mx[i]);
    for (int i = 0; i < H; i++) yq.push_back(my[i]);
    xv_cnt = 0;
    yv_cnt = 0;
    seen = 0;
    @(negedge clk) readHistogram = 1'b1;
    @(negedge clk) readHistogram = 1'b0;
    for (int c = 0; c < N + 20; c++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("read_timeout", 0, 1);
    @(negedge clk);
    check("xv_cnt", xv_cnt, W);
    check("yv_cnt", yv_cnt, H);
    check("xq_left", xq.size(), 0);
    check("yq_left", yq.size(), 0);
    xq.delete();
    yq.delete();
  endtask

  task automatic fill(int v);
    for (int i = 0; i < W; i++)
      for (int j = 0; j < H; j++) src[i][j] = v[0];
  endtask

  initial begin
    int lowc, w0, ones_cnt;
    zero_model();
    fill(0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    check("rst_frdy", int'(filterReady), 1);
    check("rst_rdy", int'(ready), 1);
    check("rst_we", int'(writeEnable), 0);
    check("rst_done", int'(filterDone), 0);
    check("rst_xv", int'(xValid), 0);
    check("rst_hclr", int'(histogramClear), 0);
    read_hist();

    fill(1);
    run_frame();
    check("corner00", int'(fm[0][0]), 0);
    check("cornerFF", int'(fm[W-1][H-1]), 0);
    check("edge05", int'(fm[0][5]), 1);
    check("inner55", int'(fm[5][5]), 1);
    read_hist();
    check("xbin0", gx[0], H - 2);
    check("xbin5", gx[5], H);
    check("ybin0", gy[0], W - 2);
    check("ybin5", gy[5], W);

    run_frame();
    read_hist();
    check("xbin0_sat", gx[0], BMAX);
    check("ybin5_sat", gy[5], BMAX);

    xv_cnt = 0;
    @(negedge clk);
    readHistogram = 1'b1;
    clearHistogram = 1'b1;
    @(negedge clk);
    readHistogram = 1'b0;
    clearHistogram = 1'b0;
    lowc = 0;
    for (int c = 0; c < N + 10; c++) begin
      if (ready) break;
      lowc++;
      @(negedge clk);
    end
    check("clr_len", lowc, N);
    check("clr_pulse", int'(histogramClear), 1);
    check("clr_no_read", xv_cnt, 0);
    zero_model();
    read_hist();

    fill(0);
    src[10][10] = 1'b1;
    run_frame();
    ones_cnt = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < H; j++) ones_cnt += fm[i][j];
    check("iso_ones", ones_cnt, 0);
    read_hist();

    for (int i = 0; i < W; i++)
      for (int j = 0; j < H; j++) src[i][j] = 1'($urandom_range(0, 1));
    run_frame();
    read_hist();

    for (int i = 0; i < W; i++) xq.push_back(mx[i]);
    for (int i = 0; i < H; i++) yq.push_back(my[i]);
    xv_cnt = 0;
    yv_cnt = 0;
    w0 = wr_cnt;
    @(negedge clk) readHistogram = 1'b1;
    @(negedge clk) readHistogram = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (N + 10) @(negedge clk);
    check("rd_start_frdy", int'(filterReady), 1);
    check("rd_start_wr", wr_cnt - w0, 0);
    check("rd_start_xv", xv_cnt, W);
    check("rd_start_yv", yv_cnt, H);

    fill(1);
    w0 = wr_cnt;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < H; j++) wq.push_back(pk(i, j, maj(i, j)));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (wr_cnt - w0 >= 30) break;
      @(negedge clk);
    end
    check("mid_writes", int'(wr_cnt - w0 >= 30), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_frdy", int'(filterReady), 1);
    check("abort_rdy", int'(ready), 1);
    check("abort_we", int'(writeEnable), 0);
    wq.delete();
    zero_model();
    @(negedge clk) reset = 1'b0;
    w0 = wr_cnt;
    repeat (100) @(negedge clk);
    check("abort_nowr", wr_cnt - w0, 0);
    read_hist();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
